banked_mem_responder: RTL and testbench

//  Main-memory side of the cache<->memory interface: four-bank interleaved word memory.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_bank_ctr.sv | 31 +++
 rtl/banked_mem_responder.sv | 123 ++++++++++++
 tb/tb_banked_mem_responder.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the banked main-memory responder: bank geometry,
// request classification and the bank-select helper.
package mem_pkg;

  localparam int NUM_BANKS    = 4;
  localparam int BANK_SEL_LSB = 1;
  localparam int BANK_SEL_MSB = 2;

  typedef logic [BANK_SEL_MSB-BANK_SEL_LSB:0] bank_idx_t;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2,
    REQ_ERR   = 2'd3
  } req_kind_t;

  // Consecutive words of a line land in consecutive banks.
  function automatic bank_idx_t bank_of(input logic [BANK_SEL_MSB:BANK_SEL_LSB] sel_bits);
    return bank_idx_t'(sel_bits);
  endfunction

endpackage

// File: rtl/mem_bank_ctr.sv
// Per-bank occupancy down-counter: a bank is occupied for BANK_LAT cycles
// including the cycle it accepts an access.
module mem_bank_ctr #(
  parameter int BANK_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_busy
);

  localparam int CW = (BANK_LAT > 1) ? $clog2(BANK_LAT) : 1;
  // The accept cycle itself is the first occupied cycle, so only the
  // remaining BANK_LAT-1 cycles are counted and shown as busy.
  localparam logic [CW-1:0] LOAD_VAL = CW'(BANK_LAT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank interleaved word memory serving cache write-back and line-fill
// bursts, with fixed read latency and per-bank busy stalls.
module banked_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 13,
  parameter int BANK_LAT   = 4,
  parameter int RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  req_kind_t               w_kind;
  bank_idx_t               w_bank;
  logic [DEPTH_LOG2-1:0]   w_word;
  logic [NUM_BANKS-1:0]    w_busy;
  logic                    w_accept;
  logic                    w_acc_rd;
  logic                    w_acc_wr;
  logic [DATA_W-1:0]       w_stage [RD_LAT];

  logic [DATA_W-1:0]       r_mem [WORDS];
  logic [DATA_W-1:0]       r_rd_word;
  logic [RD_LAT-1:0]       r_vld;

  // High word-address bits beyond the storage depth simply wrap.
  assign w_word = addr[DEPTH_LOG2:1];
  assign w_bank = bank_of(addr[BANK_SEL_MSB:BANK_SEL_LSB]);

  generate
    if (ADDR_W - 1 > DEPTH_LOG2) begin : g_wrap_bits
      logic w_unused_hi;
      assign w_unused_hi = ^addr[ADDR_W-1:DEPTH_LOG2+1];
    end
  endgenerate

  always_comb begin
    w_kind = REQ_NONE;
    if ((rd && wr) || ((rd || wr) && addr[0])) begin
      w_kind = REQ_ERR;
    end else if (wr) begin
      w_kind = REQ_WRITE;
    end else if (rd) begin
      w_kind = REQ_READ;
    end
  end

  assign err      = (w_kind == REQ_ERR);
  assign stall    = ((w_kind == REQ_READ) || (w_kind == REQ_WRITE)) && w_busy[w_bank];
  assign w_accept = ((w_kind == REQ_READ) || (w_kind == REQ_WRITE)) && !w_busy[w_bank];
  assign w_acc_rd = w_accept && (w_kind == REQ_READ);
  assign w_acc_wr = w_accept && (w_kind == REQ_WRITE);
  assign busy     = w_busy;

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      mem_bank_ctr #(
        .BANK_LAT (BANK_LAT)
      ) u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_accept && (w_bank == bank_idx_t'(gi))),
        .o_busy (w_busy[gi])
      );
    end
  endgenerate

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_acc_wr) begin
      r_mem[w_word] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc_rd) begin
      r_rd_word <= r_mem[w_word];
    end
  end

  assign w_stage[0] = r_rd_word;

  generate
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
      logic [DATA_W-1:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else begin
          r_q <= w_stage[gi-1];
        end
      end
      assign w_stage[gi] = r_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld <= (r_vld << 1) | RD_LAT'(w_acc_rd);
    end
  end

  // The RAM output register has no reset, so data is gated by its valid bit.
  assign rd_valid = r_vld[RD_LAT-1];
  assign data_out = r_vld[RD_LAT-1] ? w_stage[RD_LAT-1] : '0;

endmodule

// File: tb/tb_banked_mem_responder.sv
// Self-checking bench for banked_mem_responder: directed scenarios plus random
// traffic, all checked cycle by cycle against a cycle-count based memory model.
module tb_banked_mem_responder;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int DEPTH_LOG2 = 13;
  localparam int BANK_LAT   = 4;
  localparam int RD_LAT     = 2;
  localparam int WORDS      = 1 << DEPTH_LOG2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              stall;
  logic [3:0]        busy;
  logic              err;

  banked_mem_responder #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BANK_LAT   (BANK_LAT),
    .RD_LAT     (RD_LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .wr       (wr),
    .rd       (rd),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;

  // Model: a bank accepted in cycle c is free again from cycle c+BANK_LAT;
  // a read accepted in cycle c returns its word in cycle c+RD_LAT.
  typedef struct {
    int          due;
    logic [15:0] d;
    bit          known;
  } rd_t;

  typedef struct {
    bit          r;
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
  } op_t;

  int          cyc;
  int          bank_free [4];
  logic [15:0] mm [WORDS];
  bit          mk [WORDS];
  rd_t         rq [$];

  logic        e_err, e_stall, e_acc, e_valid;
  logic [3:0]  e_busy;
  logic [15:0] e_data, e_mask;

  function automatic int widx(input logic [15:0] a);
    return int'(a >> 1) % WORDS;
  endfunction

  task automatic model_reset();
    rq.delete();
    for (int b = 0; b < 4; b++) bank_free[b] = 0;
  endtask

  task automatic model_eval();
    e_err = (rd && wr) || ((rd || wr) && addr[0]);
    for (int b = 0; b < 4; b++) e_busy[b] = (cyc < bank_free[b]);
    e_stall = (rd != wr) && !e_err && e_busy[addr[2:1]];
    e_acc   = (rd != wr) && !e_err && !e_stall;
    e_valid = 1'b0;
    e_data  = 16'h0000;
    e_mask  = 16'hFFFF;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_valid = 1'b1;
      e_data  = rq[0].d;
      e_mask  = rq[0].known ? 16'hFFFF : 16'h0000;
    end
  endtask

  task automatic step();
    rd_t ent;
    @(posedge clk);
    if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    if (e_acc && wr) begin
      mm[widx(addr)] = data_in;
      mk[widx(addr)] = 1'b1;
      bank_free[addr[2:1]] = cyc + BANK_LAT;
      $display("cyc %0d WR addr=%h data=%h", cyc, addr, data_in);
    end
    if (e_acc && rd) begin
      ent.due   = cyc + RD_LAT;
      ent.d     = mm[widx(addr)];
      ent.known = mk[widx(addr)];
      rq.push_back(ent);
      bank_free[addr[2:1]] = cyc + BANK_LAT;
      $display("cyc %0d RD addr=%h", cyc, addr);
    end
    cyc++;
    #1;
  endtask

  task automatic set_idle();
    rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 23; k++) begin
      if (k == 3) rst_n = 1'b1;
      @(negedge clk);
      model_eval();
      checks++;
      if ({err, stall, busy, rd_valid, data_out} !== {e_err, e_stall, e_busy, e_valid, e_data}) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got err=%b stall=%b busy=%b vld=%b dout=%h exp err=%b stall=%b busy=%b vld=%b dout=%h",
                 cyc, err, stall, busy, rd_valid, data_out, e_err, e_stall, e_busy, e_valid, e_data);
      end
      step();
    end
  endtask

  task automatic test_burst();
    op_t ops [$];
    int  i = 0, guard = 0, nst = 0;
    for (int k = 0; k < 4; k++) ops.push_back('{0, 1, 16'h0100 + 16'(2*k), 16'($urandom)});
    for (int k = 0; k < 4; k++) ops.push_back('{1, 0, 16'h0100 + 16'(2*k), 16'h0});
    for (int k = 0; k < 6; k++) ops.push_back('{0, 0, 16'h0, 16'h0});
    while (i < ops.size() && guard < 100) begin
      rd = ops[i].r; wr = ops[i].w; addr = ops[i].a; data_in = ops[i].d;
      @(negedge clk);
      model_eval();
      checks++;
      if ({err, stall, busy, rd_valid, data_out & e_mask} !== {e_err, e_stall, e_busy, e_valid, e_data & e_mask}) begin
        failures++;
        $display("FAIL burst cyc=%0d got err=%b stall=%b busy=%b vld=%b dout=%h exp err=%b stall=%b busy=%b vld=%b dout=%h",
                 cyc, err, stall, busy, rd_valid, data_out, e_err, e_stall, e_busy, e_valid, e_data);
      end
      if (stall) nst++;
      if (!e_stall) i++;
      step();
      guard++;
    end
    checks++;
    if (nst !== 0 || guard >= 100) begin
      failures++;
      $display("FAIL burst_stalls got=%0d exp=0 (guard=%0d)", nst, guard);
    end
  endtask

  task automatic test_same_bank();
    op_t ops [$];
    int  i = 0, guard = 0, nst = 0;
    ops.push_back('{0, 1, 16'h0010, 16'($urandom)});
    ops.push_back('{1, 0, 16'h0018, 16'h0});
    for (int k = 0; k < 5; k++) ops.push_back('{0, 0, 16'h0, 16'h0});
    while (i < ops.size() && guard < 100) begin
      rd = ops[i].r; wr = ops[i].w; addr = ops[i].a; data_in = ops[i].d;
      @(negedge clk);
      model_eval();
      checks++;
      if ({err, stall, busy, rd_valid, data_out & e_mask} !== {e_err, e_stall, e_busy, e_valid, e_data & e_mask}) begin
        failures++;
        $display("FAIL same_bank cyc=%0d got err=%b stall=%b busy=%b vld=%b dout=%h exp err=%b stall=%b busy=%b vld=%b dout=%h",
                 cyc, err, stall, busy, rd_valid, data_out, e_err, e_stall, e_busy, e_valid, e_data);
      end
      if (stall) nst++;
      if (!e_stall) i++;
      step();
      guard++;
    end
    checks++;
    if (nst !== 3 || guard >= 100) begin
      failures++;
      $display("FAIL same_bank_stalls got=%0d exp=3 (guard=%0d)", nst, guard);
    end
  endtask

  task automatic test_err();
    op_t ops [$];
    int  i = 0, guard = 0, nerr = 0;
    ops.push_back('{1, 1, 16'h0020, 16'h1234});
    ops.push_back('{1, 0, 16'h0021, 16'h0});
    ops.push_back('{0, 1, 16'h0023, 16'h5678});
    for (int k = 0; k < 5; k++) ops.push_back('{0, 0, 16'h0, 16'h0});
    while (i < ops.size() && guard < 100) begin
      rd = ops[i].r; wr = ops[i].w; addr = ops[i].a; data_in = ops[i].d;
      @(negedge clk);
      model_eval();
      checks++;
      if ({err, stall, busy, rd_valid, data_out & e_mask} !== {e_err, e_stall, e_busy, e_valid, e_data & e_mask}) begin
        failures++;
        $display("FAIL err_req cyc=%0d got err=%b stall=%b busy=%b vld=%b dout=%h exp err=%b stall=%b busy=%b vld=%b dout=%h",
                 cyc, err, stall, busy, rd_valid, data_out, e_err, e_stall, e_busy, e_valid, e_data);
      end
      if (err) nerr++;
      if (!e_stall) i++;
      step();
      guard++;
    end
    checks++;
    if (nerr !== 3) begin
      failures++;
      $display("FAIL err_count got=%0d exp=3", nerr);
    end
  endtask

  task automatic test_reset_midburst();
    op_t ops [$];
    int  i = 0, guard = 0, nvld = 0;
    ops.push_back('{0, 1, 16'h0030, 16'($urandom)});
    for (int k = 0; k < 4; k++) ops.push_back('{0, 0, 16'h0, 16'h0});
    ops.push_back('{1, 0, 16'h0030, 16'h0});
    while (i < ops.size() && guard < 100) begin
      rd = ops[i].r; wr = ops[i].w; addr = ops[i].a; data_in = ops[i].d;
      @(negedge clk);
      model_eval();
      checks++;
      if ({err, stall, busy, rd_valid, data_out & e_mask} !== {e_err, e_stall, e_busy, e_valid, e_data & e_mask}) begin
        failures++;
        $display("FAIL rst_mid_pre cyc=%0d got err=%b stall=%b busy=%b vld=%b dout=%h exp err=%b stall=%b busy=%b vld=%b dout=%h",
                 cyc, err, stall, busy, rd_valid, data_out, e_err, e_stall, e_busy, e_valid, e_data);
      end
      if (!e_stall) i++;
      step();
      guard++;
    end
    set_idle();
    rst_n = 1'b0;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      model_eval();
      checks++;
      if ({err, stall, busy, rd_valid, data_out} !== {e_err, e_stall, e_busy, e_valid, e_data}) begin
        failures++;
        $display("FAIL rst_mid_drop cyc=%0d got err=%b stall=%b busy=%b vld=%b dout=%h exp err=%b stall=%b busy=%b vld=%b dout=%h",
                 cyc, err, stall, busy, rd_valid, data_out, e_err, e_stall, e_busy, e_valid, e_data);
      end
      if (rd_valid) nvld++;
      step();
      if (k == 0) rst_n = 1'b1;
    end
    checks++;
    if (nvld !== 0) begin
      failures++;
      $display("FAIL rst_mid_valid got=%0d exp=0", nvld);
    end
    ops.delete();
    i = 0;
    guard = 0;
    ops.push_back('{1, 0, 16'h0030, 16'h0});
    for (int k = 0; k < 4; k++) ops.push_back('{0, 0, 16'h0, 16'h0});
    while (i < ops.size() && guard < 100) begin
      rd = ops[i].r; wr = ops[i].w; addr = ops[i].a; data_in = ops[i].d;
      @(negedge clk);
      model_eval();
      checks++;
      if ({err, stall, busy, rd_valid, data_out & e_mask} !== {e_err, e_stall, e_busy, e_valid, e_data & e_mask}) begin
        failures++;
        $display("FAIL rst_mid_keep cyc=%0d got err=%b stall=%b busy=%b vld=%b dout=%h exp err=%b stall=%b busy=%b vld=%b dout=%h",
                 cyc, err, stall, busy, rd_valid, data_out, e_err, e_stall, e_busy, e_valid, e_data);
      end
      if (!e_stall) i++;
      step();
      guard++;
    end
  endtask

  task automatic test_wrap();
    op_t         ops [$];
    int          i = 0, guard = 0;
    logic [15:0] got = 16'h0000;
    ops.push_back('{0, 1, 16'h0002, 16'hBEEF});
    ops.push_back('{1, 0, 16'h0002 + 16'(1 << (DEPTH_LOG2 + 1)), 16'h0});
    for (int k = 0; k < 4; k++) ops.push_back('{0, 0, 16'h0, 16'h0});
    while (i < ops.size() && guard < 100) begin
      rd = ops[i].r; wr = ops[i].w; addr = ops[i].a; data_in = ops[i].d;
      @(negedge clk);
      model_eval();
      checks++;
      if ({err, stall, busy, rd_valid, data_out & e_mask} !== {e_err, e_stall, e_busy, e_valid, e_data & e_mask}) begin
        failures++;
        $display("FAIL wrap cyc=%0d got err=%b stall=%b busy=%b vld=%b dout=%h exp err=%b stall=%b busy=%b vld=%b dout=%h",
                 cyc, err, stall, busy, rd_valid, data_out, e_err, e_stall, e_busy, e_valid, e_data);
      end
      if (rd_valid) got = data_out;
      if (!e_stall) i++;
      step();
      guard++;
    end
    checks++;
    if (got !== 16'hBEEF) begin
      failures++;
      $display("FAIL wrap_data got=%h exp=beef", got);
    end
  endtask

  task automatic test_random();
    int sel;
    for (int k = 0; k < 306; k++) begin
      set_idle();
      if (k < 300) begin
        sel = int'($urandom_range(0, 9));
        rd = (sel <= 3) || (sel == 8);
        wr = (sel >= 4 && sel <= 8);
        addr = 16'h0200 + 16'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) addr = addr + 16'(1 << (DEPTH_LOG2 + 1));
        data_in = 16'($urandom);
      end
      @(negedge clk);
      model_eval();
      checks++;
      if ({err, stall, busy, rd_valid, data_out & e_mask} !== {e_err, e_stall, e_busy, e_valid, e_data & e_mask}) begin
        failures++;
        $display("FAIL random cyc=%0d got err=%b stall=%b busy=%b vld=%b dout=%h exp err=%b stall=%b busy=%b vld=%b dout=%h",
                 cyc, err, stall, busy, rd_valid, data_out, e_err, e_stall, e_busy, e_valid, e_data);
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    test_reset();
    test_burst();
    test_same_bank();
    test_err();
    test_reset_midburst();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
